e203_sleep_ctrl: RTL

- Low-power sequencer that sits directly upstream of the core clock controller.
- Accepts a retired-WFI request from commit, halts instruction fetch and drains outstanding activity, then raises core_wfi; wakes on a pending interrupt or debug request.
- Also filters the raw per-unit activity signals with a hold-off counter, so the downstream clock gates do not toggle on every one-cycle idle gap.
- Also counts sleep cycles for performance monitoring.

---
 rtl/e203_sleep_pkg.sv | 14 +
 rtl/e203_active_hold.sv | 38 +++
 rtl/e203_sleep_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/e203_sleep_pkg.sv
// Shared definitions for the E203 low-power sequencer: FSM state encoding and
// the width of the per-unit activity hold counters.
package e203_sleep_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } sleep_state_e;

  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/e203_active_hold.sv
// Activity hold-off filter: keeps a unit's clock-gate enable high for HOLD_CYC
// cycles after its raw activity drops, so short idle gaps never toggle the gate.
module e203_active_hold
  import e203_sleep_pkg::*;
#(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic active_o
);

  localparam logic [HOLD_CNT_W-1:0] RELOAD = HOLD_CNT_W'(HOLD_CYC);

  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (raw_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_CNT_W'(1);
    end
  end

  // Reset value keeps every unit clocked for the first HOLD_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = raw_i | (cnt_q != '0);

endmodule

// File: rtl/e203_sleep_ctrl.sv
// WFI sleep sequencer: halts fetch, drains outstanding work, raises core_wfi,
// wakes on interrupt/debug, filters unit activity and counts sleep cycles.
module e203_sleep_ctrl
  import e203_sleep_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wfi_req_valid,
  output logic             wfi_req_ready,
  output logic             halt_ifu_req,
  input  logic             ifu_halt_ack,
  input  logic             oitf_empty,
  input  logic             lsu_idle,
  input  logic             biu_idle,
  input  logic             irq_pending,
  input  logic             dbg_req,
  output logic             core_wfi,
  output logic             wake_pulse,
  input  logic             ifu_active_raw,
  input  logic             exu_active_raw,
  input  logic             lsu_active_raw,
  input  logic             biu_active_raw,
  output logic             core_ifu_active,
  output logic             core_exu_active,
  output logic             core_lsu_active,
  output logic             core_biu_active,
  input  logic             sleep_cnt_clr,
  output logic [CNT_W-1:0] sleep_cnt
);

  sleep_state_e     state_q, state_d;
  logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
  logic             wake;
  logic             drained;

  assign wake    = irq_pending | dbg_req;
  assign drained = ifu_halt_ack & oitf_empty & lsu_idle & biu_idle;

  // A WFI that arrives with a wake source already pending is a NOP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (wfi_req_valid && !wake) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wake)         state_d = ST_WAKE;
        else if (drained) state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (wake) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (sleep_cnt_clr) begin
      sleep_cnt_d = '0;
    end else if (state_q == ST_SLEEP && sleep_cnt_q != {CNT_W{1'b1}}) begin
      sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sleep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sleep_cnt_q <= sleep_cnt_d;
    end
  end

  assign core_wfi      = (state_q == ST_SLEEP);
  assign halt_ifu_req  = (state_q == ST_DRAIN) || (state_q == ST_SLEEP);
  assign wfi_req_ready = (state_q == ST_RUN);
  assign wake_pulse    = (state_q == ST_WAKE);
  assign sleep_cnt     = sleep_cnt_q;

  e203_active_hold #(.HOLD_CYC(HOLD_CYC)) u_ifu_hold (
    .clk(clk), .rst(rst), .raw_i(ifu_active_raw), .active_o(core_ifu_active)
  );
  e203_active_hold #(.HOLD_CYC(HOLD_CYC)) u_exu_hold (
    .clk(clk), .rst(rst), .raw_i(exu_active_raw), .active_o(core_exu_active)
  );
  e203_active_hold #(.HOLD_CYC(HOLD_CYC)) u_lsu_hold (
    .clk(clk), .rst(rst), .raw_i(lsu_active_raw), .active_o(core_lsu_active)
  );
  e203_active_hold #(.HOLD_CYC(HOLD_CYC)) u_biu_hold (
    .clk(clk), .rst(rst), .raw_i(biu_active_raw), .active_o(core_biu_active)
  );

endmodule
